mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter MAX_OUTSTANDING, default 2: max granted-but-unanswered transactions (1..4).
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive data grants while instr waits before instr is forced.
REQ-004 clk  in  1  clock, rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 instr_req_i  in  1  fetch request; held with address until granted.
REQ-007 instr_addr_i  in  32  fetch word address.
REQ-008 instr_gnt_o  out  1  fetch request accepted this cycle.
REQ-009 instr_rvalid_o  out  1  fetch response valid.
REQ-010 instr_kill_i  in  1  discard all outstanding fetch responses (PC change).
REQ-011 data_req_i  in  1  load/store request; held with attributes until granted.
REQ-012 data_we_i  in  1  1 = store.
REQ-013 data_be_i  in  4  byte enables.
REQ-014 data_addr_i  in  32  load/store address.
REQ-015 data_wdata_i  in  32  store data.
REQ-016 data_gnt_o  out  1  load/store request accepted this cycle.
REQ-017 data_rvalid_o  out  1  load/store response valid (stores included).
REQ-018 rsp_rdata_o  out  32  response data, shared, qualified by either rvalid.
REQ-019 rsp_err_o  out  1  response error, shared, qualified by either rvalid.
REQ-020 mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  out  1/1/4/32/32  shared memory request.
REQ-021 mem_gnt_i / mem_rvalid_i / mem_err_i  in  1 each  memory grant, response valid, error.
REQ-022 mem_rdata_i  in  32  memory response data.

Function
REQ-023 Owner select: data wins when both request, except forced instr when starve counter = STARVE_LIMIT.
REQ-024 FSM IDLE/WAIT_GNT: IDLE + mem_req_o & !mem_gnt_i -> WAIT_GNT, owner latched; WAIT_GNT + mem_gnt_i -> IDLE.
REQ-025 In WAIT_GNT owner and all mem_* request fields SHALL stay stable; a new higher-priority request cannot preempt.
REQ-026 mem_req_o = selected requester's req AND outstanding count < MAX_OUTSTANDING; else 0, no grant.
REQ-027 mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0 when owner is instr.
REQ-028 instr_gnt_o / data_gnt_o = mem_req_o & mem_gnt_i & owner match, same cycle (combinational, zero latency).
REQ-029 Owner FIFO, depth MAX_OUTSTANDING: push {owner, discard=0} on handshake; pop on mem_rvalid_i; push+pop same cycle keeps count.
REQ-030 On mem_rvalid_i, head owner selects instr_rvalid_o or data_rvalid_o same cycle; rsp_rdata_o = mem_rdata_i, rsp_err_o = mem_err_i.
REQ-031 instr_kill_i SHALL set discard on every queued instr entry plus any instr entry pushed that cycle; discarded responses pop silently.
REQ-032 instr_kill_i SHALL NOT affect data entries nor an instr request still in WAIT_GNT (request completes, response then discarded).
REQ-033 mem_rvalid_i with empty FIFO SHALL be ignored: no rvalid out, no count change.
REQ-034 Starve counter: +1 on each data grant while instr_req_i high, saturating at STARVE_LIMIT; cleared on instr grant or instr_req_i low.

Reset
REQ-035 rst SHALL asynchronously force FSM IDLE, FIFO empty, count 0, starve counter 0; all outputs 0 while rst high.
REQ-036 Reset mid-transaction SHALL drop all outstanding entries; late responses after release fall under REQ-033.

Verification
REQ-037 Both req, mem_gnt_i=1, mem_rvalid_i 1 cycle later -> data_gnt_o first, data_rvalid_o with rsp_rdata_o=mem_rdata_i, instr granted next cycle.
REQ-038 data_req_i held 1 and instr_req_i held 1, STARVE_LIMIT=4 -> 4 data grants then instr_gnt_o, counter cleared.
REQ-039 mem_gnt_i=0 3 cycles, instr owner, data_req_i rises cycle 1 -> mem_addr_o stays instr_addr_i; instr_gnt_o on 4th cycle.
REQ-040 MAX_OUTSTANDING=2, 2 grants, no rvalid -> mem_req_o=0; one mem_rvalid_i -> mem_req_o=1 next cycle.
REQ-041 Instr, data, instr outstanding; instr_kill_i pulse; 3 rvalids -> only data_rvalid_o asserts (2nd response).
REQ-042 rst pulse with 2 outstanding, then mem_rvalid_i=1 -> no rvalid outputs, mem_req_o=0 until new request.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (fetch/load-store) arbiter onto one pipelined memory port.
// Tracks outstanding transactions so responses route back to their owner.
module mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic        instr_kill_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic        mem_err_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, WAIT_GNT} state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 sel_instr, owner_instr, owner_req;
    logic                 req, push, pop;
    logic                 head_instr, head_disc;
    logic [MAX_OUTSTANDING-1:0] fifo_instr, fifo_disc, instr_d, disc_d;
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count;
    logic [SW-1:0]        starve;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Owner is frozen while a request waits for its grant.
    assign sel_instr   = instr_req_i &
                         (~data_req_i | (starve == SW'(STARVE_LIMIT)));
    assign owner_instr = (state_q == WAIT_GNT) ? owner_q : sel_instr;
    assign owner_req   = owner_instr ? instr_req_i : data_req_i;
    assign req         = owner_req & (count < CW'(MAX_OUTSTANDING)) & ~rst;
    assign push        = req & mem_gnt_i;
    assign pop         = mem_rvalid_i & (count != '0);
    assign head_instr  = fifo_instr[rd_ptr];
    assign head_disc   = fifo_disc[rd_ptr];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (req && !mem_gnt_i) begin
                    state_d = WAIT_GNT;
                    owner_d = owner_instr;
                end
            end
            WAIT_GNT: begin
                if (mem_gnt_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // A kill marks every queued fetch, including one pushed this cycle.
    always_comb begin
        instr_d = fifo_instr;
        disc_d  = fifo_disc | (instr_kill_i ? fifo_instr : '0);
        if (push) begin
            instr_d[wr_ptr] = owner_instr;
            disc_d[wr_ptr]  = owner_instr & instr_kill_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_instr <= '0;
            fifo_disc  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            fifo_instr <= instr_d;
            fifo_disc  <= disc_d;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
        end else if (instr_gnt_o || !instr_req_i) begin
            starve <= '0;
        end else if (data_gnt_o && starve != SW'(STARVE_LIMIT)) begin
            starve <= starve + SW'(1);
        end
    end

    always_comb begin
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_be_o       = 4'h0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        instr_gnt_o    = 1'b0;
        data_gnt_o     = 1'b0;
        instr_rvalid_o = 1'b0;
        data_rvalid_o  = 1'b0;
        rsp_rdata_o    = '0;
        rsp_err_o      = 1'b0;
        if (!rst) begin
            mem_req_o      = req;
            mem_we_o       = owner_instr ? 1'b0  : data_we_i;
            mem_be_o       = owner_instr ? 4'hF  : data_be_i;
            mem_addr_o     = owner_instr ? instr_addr_i : data_addr_i;
            mem_wdata_o    = owner_instr ? 32'h0 : data_wdata_i;
            instr_gnt_o    = push & owner_instr;
            data_gnt_o     = push & ~owner_instr;
            instr_rvalid_o = pop & head_instr & ~head_disc & ~instr_kill_i;
            data_rvalid_o  = pop & ~head_instr;
            rsp_rdata_o    = mem_rdata_i;
            rsp_err_o      = mem_err_i;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a queue-based reference model.
// Phases bias grant, response, kill and reset rates.
module tb_mem_arbiter;

    localparam int MAXO = 2;
    localparam int SL   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_kill_i;
    logic [31:0] instr_addr_i;
    logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_kill_i(instr_kill_i),
        .data_req_i(data_req_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: list of outstanding transactions in issue order.
    typedef struct { bit instr; bit disc; } ent_t;
    ent_t q[$];
    int   starve;
    bit   waiting, w_instr;

    bit e_own, e_req, e_ignt, e_dgnt, e_pop, e_irv, e_drv;
    bit saw_ignt, saw_dgnt;

    task automatic model_reset();
        q.delete();
        starve  = 0;
        waiting = 0;
        w_instr = 0;
    endtask

    task automatic model_eval();
        bit oreq;
        if (waiting) e_own = w_instr;
        else e_own = instr_req_i && (!data_req_i || starve == SL);
        oreq   = e_own ? instr_req_i : data_req_i;
        e_req  = oreq && (q.size() < MAXO);
        e_ignt = e_req && mem_gnt_i && e_own;
        e_dgnt = e_req && mem_gnt_i && !e_own;
        e_pop  = mem_rvalid_i && (q.size() > 0);
        e_irv  = e_pop && q[0].instr && !q[0].disc && !instr_kill_i;
        e_drv  = e_pop && !q[0].instr;
    endtask

    task automatic model_step();
        ent_t e;
        if (e_pop) void'(q.pop_front());
        if (instr_kill_i)
            foreach (q[i]) if (q[i].instr) q[i].disc = 1;
        if (e_ignt || e_dgnt) begin
            e.instr = e_own;
            e.disc  = e_own && instr_kill_i;
            q.push_back(e);
        end
        if (e_ignt || !instr_req_i) starve = 0;
        else if (e_dgnt && starve < SL) starve++;
        if (!waiting) begin
            if (e_req && !mem_gnt_i) begin
                waiting = 1;
                w_instr = e_own;
            end
        end else if (mem_gnt_i) begin
            waiting = 0;
        end
    endtask

    task automatic check_outputs();
        if (rst) begin
            chk("rst_outs",
                {mem_req_o, mem_we_o, mem_be_o, instr_gnt_o, data_gnt_o,
                 instr_rvalid_o, data_rvalid_o, rsp_err_o}, 64'h0);
            chk("rst_buses", {mem_addr_o, mem_wdata_o}, 64'h0);
            chk("rst_rdata", rsp_rdata_o, 64'h0);
            return;
        end
        chk("mem_req", mem_req_o, e_req);
        if (e_req) begin
            if (e_own) begin
                chk("mem_attr", {mem_we_o, mem_be_o}, 5'h0F);
                chk("mem_addr", mem_addr_o, instr_addr_i);
                chk("mem_wdata", mem_wdata_o, 64'h0);
            end else begin
                chk("mem_attr", {mem_we_o, mem_be_o}, {data_we_i, data_be_i});
                chk("mem_addr", mem_addr_o, data_addr_i);
                chk("mem_wdata", mem_wdata_o, data_wdata_i);
            end
        end
        chk("gnt", {instr_gnt_o, data_gnt_o}, {e_ignt, e_dgnt});
        chk("rvalid", {instr_rvalid_o, data_rvalid_o}, {e_irv, e_drv});
        if (e_irv || e_drv)
            chk("rsp", {rsp_err_o, rsp_rdata_o}, {mem_err_i, mem_rdata_i});
    endtask

    function automatic bit roll(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic drive(input int preq, input int pgnt, input int prv,
                         input int pkill);
        if (!(instr_req_i && !saw_ignt)) begin
            instr_req_i  = roll(preq);
            instr_addr_i = $urandom & 32'hFFFF_FFFC;
        end
        if (!(data_req_i && !saw_dgnt)) begin
            data_req_i   = roll(preq);
            data_we_i    = roll(50);
            data_be_i    = 4'($urandom);
            data_addr_i  = $urandom;
            data_wdata_i = $urandom;
        end
        mem_gnt_i    = roll(pgnt);
        mem_rvalid_i = roll(prv);
        mem_err_i    = roll(10);
        mem_rdata_i  = $urandom;
        instr_kill_i = roll(pkill);
    endtask

    task automatic run(input int n, input int preq, input int pgnt,
                       input int prv, input int pkill, input int prst);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            if (!rst) model_step();
            #1;
            if (rst) begin
                rst = 1'b0;
                model_reset();
            end else if (roll(prst)) begin
                rst = 1'b1;
                model_reset();
            end
            drive(preq, pgnt, prv, pkill);
            @(negedge clk);
            model_eval();
            check_outputs();
            saw_ignt = instr_gnt_o;
            saw_dgnt = data_gnt_o;
        end
    endtask

    initial begin
        rst          = 1'b1;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_1000;
        instr_kill_i = 1'b0;
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'h3;
        data_addr_i  = 32'h2000_0000;
        data_wdata_i = 32'hDEAD_BEEF;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_err_i    = 1'b1;
        mem_rdata_i  = 32'hCAFE_F00D;
        saw_ignt     = 1'b0;
        saw_dgnt     = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        check_outputs();

        run(300, 70, 70, 50, 5, 0);
        run(200, 100, 100, 60, 0, 0);
        run(200, 80, 25, 40, 5, 0);
        run(200, 90, 90, 5, 10, 0);
        run(300, 70, 60, 50, 10, 3);
        run(100, 60, 60, 50, 5, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
